// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM state encoding and
// the radix-4 Booth partial-product select codes.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Multiples of the multiplicand a Booth triplet can select: 0, +1, +2, -1, -2
  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_sel_t;

endpackage

// File: rtl/multdiv_unit_booth_recoder.sv
// Radix-4 Booth recoder: {m[i+1], m[i], m[i-1]} -> partial-product select.
// Purely combinational, zero latency, no flow control.
module booth_recoder
  import multdiv_pkg::*;
(
  input  logic [2:0]  bits,
  output booth_sel_t  sel
);

  always_comb begin
    sel = BOOTH_ZERO;
    case (bits)
      3'b001, 3'b010: sel = BOOTH_POS1;
      3'b011:         sel = BOOTH_POS2;
      3'b100:         sel = BOOTH_NEG2;
      3'b101, 3'b110: sel = BOOTH_NEG1;
      default:        sel = BOOTH_ZERO;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide; MULTDIV_BOOTH_EN selects radix-4 Booth multiply.
// Latency WIDTH+1 cycles (WIDTH/2+1 Booth multiply, 1 for divide-by-zero); no backpressure, busy stalls the pipe.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef MULTDIV_BOOTH_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH/2 - 1);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
`endif
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // {partial product hi, multiplier shifting out}
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   dvd_q;    // dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   rem;
  logic               q_neg;

  logic               start_mul, start_div, accept, div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     prod_top;
  logic               mul_exc;
  logic [WIDTH:0]     rem_sh, trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt, q_nxt, div_res;
  logic               div_exc;

  assign start_mul   = ctrl_MULT & ~ctrl_DIV;
  assign start_div   = ctrl_DIV & ~ctrl_MULT;
  assign accept      = (state != DONE);
  assign div_by_zero = (data_operandB == '0);
  assign a_mag       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_BOOTH_EN
  logic [WIDTH+1:0] hi_ext, mc_ext, mul_sum;
  booth_sel_t       pp_sel;
  logic             booth_prev;

  booth_recoder u_booth_recoder (
    .bits ({acc[1:0], booth_prev}),
    .sel  (pp_sel)
  );

  assign hi_ext = {{2{acc[2*WIDTH-1]}}, acc[2*WIDTH-1:WIDTH]};
  assign mc_ext = {{2{mcand[WIDTH-1]}}, mcand};

  always_comb begin
    mul_sum = hi_ext;
    case (pp_sel)
      BOOTH_POS1: mul_sum = hi_ext + mc_ext;
      BOOTH_POS2: mul_sum = hi_ext + (mc_ext << 1);
      BOOTH_NEG1: mul_sum = hi_ext - mc_ext;
      BOOTH_NEG2: mul_sum = hi_ext - (mc_ext << 1);
      default:    mul_sum = hi_ext;
    endcase
  end

  assign mul_nxt = {mul_sum, acc[WIDTH-1:2]};

  always_ff @(posedge clock) begin
    if (reset)
      booth_prev <= 1'b0;
    else if (accept && start_mul)
      booth_prev <= 1'b0;
    else if (state == MUL)
      booth_prev <= acc[1];
  end
`else
  logic [WIDTH:0] hi_ext, mc_ext, mul_sum;

  assign hi_ext = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
  assign mc_ext = {mcand[WIDTH-1], mcand};

  // The multiplier's top bit carries weight -2^(WIDTH-1), hence subtract on the last step
  always_comb begin
    mul_sum = hi_ext;
    if (acc[0])
      mul_sum = (cnt == MUL_LAST) ? hi_ext - mc_ext : hi_ext + mc_ext;
  end

  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};
`endif

  assign prod_top = mul_nxt[2*WIDTH-1:WIDTH-1];
  assign mul_exc  = ~((&prod_top) | ~(|prod_top));

  assign rem_sh  = {rem, dvd_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvsr};
  assign q_bit   = ~trial[WIDTH];
  assign rem_nxt = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_nxt   = {dvd_q[WIDTH-2:0], q_bit};
  assign div_res = q_neg ? -q_nxt : q_nxt;
  // Only -2^(WIDTH-1) / -1 yields a positive quotient with the top bit set
  assign div_exc = ~q_neg & q_nxt[WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, MUL, DIV: begin
        if (start_mul)
          state_nxt = MUL;
        else if (start_div)
          state_nxt = div_by_zero ? DONE : DIV;
        else if (state == MUL && cnt == MUL_LAST)
          state_nxt = DONE;
        else if (state == DIV && cnt == DIV_LAST)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (state == DONE);
    busy           = (state == MUL) || (state == DIV);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      dvd_q          <= '0;
      dvsr           <= '0;
      rem            <= '0;
      q_neg          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (accept && start_mul) begin
      cnt   <= '0;
      mcand <= data_operandA;
      acc   <= {{WIDTH{1'b0}}, data_operandB};
    end else if (accept && start_div) begin
      cnt <= '0;
      if (div_by_zero) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else begin
        dvd_q <= a_mag;
        dvsr  <= b_mag;
        rem   <= '0;
        q_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end
    end else if (state == MUL) begin
      acc <= mul_nxt;
      cnt <= cnt + CNT_W'(1);
      if (cnt == MUL_LAST) begin
        data_result    <= mul_nxt[WIDTH-1:0];
        data_exception <= mul_exc;
      end
    end else if (state == DIV) begin
      dvd_q <= q_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (cnt == DIV_LAST) begin
        data_result    <= div_res;
        data_exception <= div_exc;
      end
    end
  end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; even, >= 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: iteration counter width.
REQ-003 clock  input  1  master clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ctrl_MULT  input  1  one-cycle start pulse, signed multiply.
REQ-006 ctrl_DIV  input  1  one-cycle start pulse, signed divide (quotient).
REQ-007 data_operandA  input  WIDTH  multiplicand / dividend; sampled only on a start edge.
REQ-008 data_operandB  input  WIDTH  multiplier / divisor; sampled only on a start edge.
REQ-009 data_result  output  WIDTH  product low WIDTH bits or quotient; held until next start.
REQ-010 data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY is high.
REQ-011 data_resultRDY  output  1  one-cycle pulse marking result valid.
REQ-012 busy  output  1  high while an operation is in progress; used by the pipeline to stall.

Function
REQ-013 FSM states IDLE, MUL, DIV, DONE; exactly one state active.
REQ-014 IDLE: ctrl_MULT=1, ctrl_DIV=0 -> latch operands, clear counter, go to MUL.
REQ-015 IDLE: ctrl_DIV=1, ctrl_MULT=0, operandB!=0 -> latch magnitudes and signs, go to DIV.
REQ-016 IDLE: ctrl_DIV=1, operandB==0 -> go to DONE; result 0, exception 1.
REQ-017 ctrl_MULT and ctrl_DIV both high on the same edge -> ignored, no state change.
REQ-018 MUL: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit signed accumulator; final step subtracts for the multiplier sign bit.
REQ-019 DIV: restoring divide on magnitudes, one quotient bit per cycle; quotient negated when operand signs differ.
REQ-020 MUL/DIV leave for DONE when counter reaches WIDTH; counter increments once per cycle.
REQ-021 DONE: data_resultRDY=1 for exactly one cycle, busy=0, data_result/data_exception updated; next state IDLE.
REQ-022 Latency: start sampled on edge N -> data_resultRDY high in the cycle after edge N+WIDTH+1 (33 cycles at WIDTH=32); divide-by-zero: in the cycle after edge N+1.
REQ-023 Multiply exception=1 iff the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
REQ-024 Divide exception=1 for divisor 0, or dividend = -2^(WIDTH-1) with divisor -1 (result -2^(WIDTH-1)).
REQ-025 A new start pulse in MUL or DIV aborts the current operation and restarts with new operands, same rules as IDLE; no RDY for the aborted operation.
REQ-026 busy=1 in MUL and DIV only.
REQ-027 data_result and data_exception hold their last values in IDLE, MUL and DIV.

Reset
REQ-028 reset=1 at an edge -> state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0.
REQ-029 reset overrides simultaneous start pulses; an in-flight operation is discarded with no RDY.

Configuration
REQ-030 Macro MULTDIV_BOOTH_EN defined -> MUL uses radix-4 Booth recoding, two bits per cycle; MUL exits at counter WIDTH/2; multiply latency WIDTH/2+1 edges (17 at WIDTH=32).
REQ-031 Macro MULTDIV_BOOTH_EN undefined -> radix-2 per REQ-018; divide path identical in both builds.

Structure
REQ-032 Shared package multdiv_pkg holds the FSM state enum (IDLE, MUL, DIV, DONE) and Booth recode constants (0, +1, +2, -1, -2).
REQ-033 One sub-module, booth_recoder: combinational, 3 multiplier bits -> partial-product select; instantiated only when MULTDIV_BOOTH_EN is defined.
REQ-034 Counter, FSM, accumulator and divider remainder registers are flat in multdiv_unit.

Verification
REQ-035 WIDTH=32, MULT 7 x -6 -> RDY at 33rd cycle (17th with Booth), result 0xFFFFFFD6, exception 0, busy high exactly 32 (16) cycles.
REQ-036 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; MULT 0x80000000 x 1 -> 0x80000000, exception 0.
REQ-037 DIV -17 / 5 -> result -3 (0xFFFFFFFD), exception 0; DIV 0x80000000 / -1 -> 0x80000000, exception 1.
REQ-038 DIV 123 / 0 -> RDY one cycle after start, result 0, exception 1, busy never high.
REQ-039 MULT 3x4 started, DIV 100/7 pulsed 10 cycles later -> single RDY for result 14 at 33 cycles after the DIV pulse; reset asserted mid-DIV -> no RDY, all outputs 0 next cycle.
REQ-040 Random signed operands at WIDTH=8 and WIDTH=32, both builds, vs. reference model: results and exceptions match; ctrl_MULT and ctrl_DIV pulsed together -> no state change.
